// File: rtl/prbs_checker.sv
// Serial PRBS checker: self-synchronises to a Fibonacci LFSR stream, reports lock,
// and counts bit errors and checked bits while locked.
module prbs_checker #(
    parameter int unsigned N           = 7,
    parameter int unsigned TAP         = 6,
    parameter int unsigned LOCK_COUNT  = 32,
    parameter int unsigned WINDOW      = 128,
    parameter int unsigned UNLOCK_ERRS = 8,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned FW = $clog2(N + 1);
    localparam int unsigned MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int unsigned WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned EW = $clog2(UNLOCK_ERRS + 1);

    localparam logic [FW-1:0]    FillFull  = FW'(N);
    localparam logic [MW-1:0]    MatchLast = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0]    WinLast   = WW'(WINDOW - 1);
    localparam logic [EW-1:0]    ErrLimit  = EW'(UNLOCK_ERRS);
    localparam logic [CNT_W-1:0] CntMax    = '1;

    typedef enum logic {StSearch, StLocked} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     s_q, s_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic [CNT_W-1:0] bit_count_q, bit_count_d;

    logic          pred;
    logic          mis;
    logic [EW-1:0] win_err_next;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StSearch;
            s_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
            bit_count_q <= '0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
            bit_count_q <= bit_count_d;
        end
    end

    // Next-state: search loads received bits, locked free-runs on the prediction.
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        fill_d       = fill_q;
        match_d      = match_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        err_pulse_d  = 1'b0;
        err_count_d  = err_count_q;
        bit_count_d  = bit_count_q;
        pred         = s_q[N-1] ^ s_q[TAP-1];
        mis          = in_bit ^ pred;
        win_err_next = win_err_q + EW'(mis);

        if (in_valid) begin
            case (state_q)
                StSearch: begin
                    s_d = {s_q[N-2:0], in_bit};
                    if (fill_q != FillFull) begin
                        fill_d = fill_q + FW'(1);
                    end
                    // A zero register predicts zero forever, so it never counts as a match.
                    if (fill_q == FillFull && !mis && s_q != '0) begin
                        if (match_q == MatchLast) begin
                            state_d = StLocked;
                            match_d = '0;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                StLocked: begin
                    s_d = {s_q[N-2:0], pred};
                    if (bit_count_q != CntMax) begin
                        bit_count_d = bit_count_q + CNT_W'(1);
                    end
                    if (mis) begin
                        err_pulse_d = 1'b1;
                        if (err_count_q != CntMax) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                    end
                    // Unlock takes priority over a window wrap on the same bit.
                    if (win_err_next >= ErrLimit) begin
                        state_d   = StSearch;
                        fill_d    = '0;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WinLast) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WW'(1);
                        win_err_d = win_err_next;
                    end
                end
                default: state_d = StSearch;
            endcase
        end

        if (clr_counts) begin
            err_count_d = '0;
            bit_count_d = '0;
        end
    end

    assign locked    = (state_q == StLocked);
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;
    assign bit_count = bit_count_q;

endmodule
